memwrite_checker: RTL and testbench
===================================

# memwrite_checker

Synthesizable, parametrised memory-write scoreboard for the MIPS core's data-memory port. It watches `memwrite`/`dataadr`/`writedata` from `top` and checks them against a programmed sequence of up to DEPTH expected (address, data) writes, in order. It reports pass, fail, cause and failing index, with a watchdog timeout. It replaces single-address, single-value pass/fail checking, and can sit in the bench or on an FPGA build as a self-test monitor.

## Interface
- WIDTH, 32, data and address width
- DEPTH, 8, maximum number of expected writes (≥1)
- TIMEOUT, 1000, watchdog limit in cycles since arm or since the last matched write; 0 disables the watchdog
- IW, $clog2(DEPTH+1), width of index and count fields (localparam)

- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- cfg_we  in  1  write one expected entry (ignored while RUN)
- cfg_idx  in  IW  entry index 0..DEPTH-1; out-of-range writes are dropped
- cfg_addr  in  WIDTH  expected address
- cfg_data  in  WIDTH  expected data
- cfg_len  in  IW  number of entries to check, latched on start; values above DEPTH are clamped to DEPTH
- start  in  1  one-cycle arm pulse
- memwrite  in  1  monitored write strobe
- dataadr  in  WIDTH  monitored address
- writedata  in  WIDTH  monitored data
- busy  out  1  high in RUN
- done  out  1  high in PASS or FAIL
- pass  out  1  high in PASS
- fail  out  1  high in FAIL
- fail_cause  out  2  0 none, 1 address, 2 data, 3 timeout
- fail_idx  out  IW  expected-entry index at the point of failure
- match_cnt  out  IW  number of writes matched so far
- fail_addr, fail_data  out  WIDTH  offending write captured on an address or data failure; 0 on timeout

## Operation
- States: IDLE, RUN, PASS, FAIL.
- Reset: state IDLE; all outputs 0; len, idx and watchdog cleared. The expected table is not reset and keeps its contents.
- IDLE, PASS, FAIL + start:
  - latch len, clear idx, match_cnt, watchdog and fail_* fields.
  - len=0 → PASS; otherwise → RUN.
- RUN with memwrite=1, comparing against entry table[idx]:
  - dataadr==addr and writedata==data → idx++, match_cnt++, watchdog cleared; if idx+1==len → PASS.
  - dataadr==addr and data differs → FAIL, cause 2.
  - dataadr≠addr → FAIL, cause 1 (see Configuration).
- RUN, no write, TIMEOUT≠0 and watchdog reaches TIMEOUT-1 → FAIL, cause 3.
- start while RUN is ignored. memwrite outside RUN is ignored.
- PASS and FAIL are sticky until start or reset. fail_idx = idx at the failing event.
- cfg_we while not RUN writes table[cfg_idx] at the edge. cfg_we together with start: the cfg write lands first, then start latches; the new entry is used.

## Timing
- Monitored inputs are sampled on the rising edge. A match or failure updates the state and outputs at that same edge, so results are visible one cycle after the write cycle.
- Back-to-back writes on every cycle are supported, with no stall.
- Watchdog counts cycles in RUN. With TIMEOUT=N and no matching write, fail rises N cycles after entering RUN.
- Reset asserted mid-RUN → IDLE immediately, without waiting for a clock edge.

## Configuration
- MEMCHK_FILTER_EN defined: a write whose address differs from the current expected address is ignored. It causes no failure and does not clear the watchdog. Cause 1 never occurs.
- MEMCHK_FILTER_EN undefined: any address mismatch in RUN → FAIL, cause 1 (strict mode, default).

## Test plan
- Program entry 0 = (80, 0xFFFFFFFA), len=1, start, then write (80, 0xFFFFFFFA) → pass=1 next cycle, match_cnt=1, fail_cause=0.
- Program 3 entries (0x10,1), (0x14,2), (0x18,3), then drive them on consecutive cycles → pass after the third, match_cnt=3. Repeat with the middle write's data set to 5 → fail, cause 2, fail_idx=1, fail_data=5.
- Strict build, write (84, 7) while expecting address 80 → fail, cause 1, fail_addr=84. With MEMCHK_FILTER_EN defined, the same write is ignored and the following correct write passes.
- TIMEOUT=20, arm, no writes → fail and cause 3 exactly 20 cycles after busy rises. TIMEOUT=0 → still busy after 5000 cycles.
- Assert reset mid-RUN after 1 match → all outputs 0 immediately. Restart with start → a full pass is achieved using the retained table.
- start with cfg_len=0 → pass next cycle. start during RUN → no effect on idx or watchdog.

Source files
------------

// File: rtl/memwrite_checker.sv
// Memory-write scoreboard: checks monitored (address, data) writes against a programmed in-order table.
// Define MEMCHK_FILTER_EN to ignore writes to unexpected addresses instead of failing on them.
module memwrite_checker #(
  parameter  int WIDTH   = 32,
  parameter  int DEPTH   = 8,
  parameter  int TIMEOUT = 1000,
  localparam int IW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [IW-1:0]    cfg_idx,
  input  logic [WIDTH-1:0] cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic [IW-1:0]    cfg_len,
  input  logic             start,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] dataadr,
  input  logic [WIDTH-1:0] writedata,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_cause,
  output logic [IW-1:0]    fail_idx,
  output logic [IW-1:0]    match_cnt,
  output logic [WIDTH-1:0] fail_addr,
  output logic [WIDTH-1:0] fail_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] DEPTH_IW = IW'(DEPTH);
  localparam logic [WW-1:0] WD_LAST  = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t           state, state_n;
  logic [IW-1:0]    len, len_n, idx, idx_n, cnt_n, fidx_n;
  logic [WW-1:0]    wdog, wdog_n;
  logic [1:0]       cause_n;
  logic [WIDTH-1:0] faddr_n, fdata_n;
  logic [IW-1:0]    idx_inc, len_start;
  logic             addr_hit, addr_miss;

  // Expected table has no reset so it survives a reset and can be replayed.
  logic [WIDTH-1:0] exp_addr [DEPTH];
  logic [WIDTH-1:0] exp_data [DEPTH];

  always_ff @(posedge clk) begin
    if (cfg_we && state != S_RUN && cfg_idx < DEPTH_IW) begin
      exp_addr[cfg_idx[AW-1:0]] <= cfg_addr;
      exp_data[cfg_idx[AW-1:0]] <= cfg_data;
    end
  end

  assign idx_inc   = idx + 1'b1;
  assign len_start = (cfg_len > DEPTH_IW) ? DEPTH_IW : cfg_len;
  assign addr_hit  = memwrite && (dataadr == exp_addr[idx[AW-1:0]]);
`ifdef MEMCHK_FILTER_EN
  assign addr_miss = 1'b0;
`else
  assign addr_miss = memwrite && (dataadr != exp_addr[idx[AW-1:0]]);
`endif

  always_comb begin
    state_n = state;
    len_n   = len;
    idx_n   = idx;
    cnt_n   = match_cnt;
    wdog_n  = wdog;
    cause_n = fail_cause;
    fidx_n  = fail_idx;
    faddr_n = fail_addr;
    fdata_n = fail_data;
    case (state)
      S_RUN: begin
        if (addr_hit && writedata == exp_data[idx[AW-1:0]]) begin
          idx_n  = idx_inc;
          cnt_n  = match_cnt + 1'b1;
          wdog_n = '0;
          if (idx_inc == len) state_n = S_PASS;
        end else if (addr_hit || addr_miss) begin
          state_n = S_FAIL;
          cause_n = addr_hit ? 2'd2 : 2'd1;
          fidx_n  = idx;
          faddr_n = dataadr;
          fdata_n = writedata;
        end else if (TIMEOUT != 0 && wdog == WD_LAST) begin
          state_n = S_FAIL;
          cause_n = 2'd3;
          fidx_n  = idx;
          faddr_n = '0;
          fdata_n = '0;
        end else begin
          wdog_n = wdog + 1'b1;
        end
      end
      default: begin
        if (start) begin
          len_n   = len_start;
          idx_n   = '0;
          cnt_n   = '0;
          wdog_n  = '0;
          cause_n = 2'd0;
          fidx_n  = '0;
          faddr_n = '0;
          fdata_n = '0;
          state_n = (len_start == '0) ? S_PASS : S_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      len        <= '0;
      idx        <= '0;
      wdog       <= '0;
      match_cnt  <= '0;
      fail_cause <= 2'd0;
      fail_idx   <= '0;
      fail_addr  <= '0;
      fail_data  <= '0;
    end else begin
      state      <= state_n;
      len        <= len_n;
      idx        <= idx_n;
      wdog       <= wdog_n;
      match_cnt  <= cnt_n;
      fail_cause <= cause_n;
      fail_idx   <= fidx_n;
      fail_addr  <= faddr_n;
      fail_data  <= fdata_n;
    end
  end

  assign busy = (state == S_RUN);
  assign pass = (state == S_PASS);
  assign fail = (state == S_FAIL);
  assign done = pass || fail;

endmodule

// File: tb/tb_memwrite_checker.sv
// Directed self-checking bench for memwrite_checker (TIMEOUT=20 instance plus a TIMEOUT=0 instance).
// Expectations follow MEMCHK_FILTER_EN when the bench is built with it.
module tb_memwrite_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [3:0]  cfg_idx;
  logic [31:0] cfg_addr, cfg_data;
  logic [3:0]  cfg_len;
  logic        start, memwrite;
  logic [31:0] dataadr, writedata;

  logic        busy, done, pass, fail;
  logic [1:0]  fail_cause;
  logic [3:0]  fail_idx, match_cnt;
  logic [31:0] fail_addr, fail_data;

  logic        nw_busy, nw_done, nw_pass, nw_fail;
  logic [1:0]  nw_fail_cause;
  logic [3:0]  nw_fail_idx, nw_match_cnt;
  logic [31:0] nw_fail_addr, nw_fail_data;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  memwrite_checker #(.WIDTH(32), .DEPTH(8), .TIMEOUT(20)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_len(cfg_len),
    .start(start), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .fail_cause(fail_cause),
    .fail_idx(fail_idx), .match_cnt(match_cnt), .fail_addr(fail_addr), .fail_data(fail_data)
  );

  memwrite_checker #(.WIDTH(32), .DEPTH(8), .TIMEOUT(0)) u_nowd (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_len(cfg_len),
    .start(start), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .busy(nw_busy), .done(nw_done), .pass(nw_pass), .fail(nw_fail), .fail_cause(nw_fail_cause),
    .fail_idx(nw_fail_idx), .match_cnt(nw_match_cnt), .fail_addr(nw_fail_addr), .fail_data(nw_fail_data)
  );

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] i, input logic [31:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_idx = i; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic arm(input logic [3:0] l);
    cfg_len = l; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    tick();
    memwrite = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
    cfg_len = '0; start = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
    tick(); tick();
    check_output("reset_busy", busy, 0);
    check_output("reset_done", done, 0);
    check_output("reset_cause", fail_cause, 0);
    check_output("reset_cnt", match_cnt, 0);
    reset = 1'b0;
    tick();

    // Single-entry pass
    cfg_write(0, 80, 32'hFFFF_FFFA);
    arm(1);
    check_output("single_busy", busy, 1);
    apply_stimulus(80, 32'hFFFF_FFFA);
    check_output("single_pass", pass, 1);
    check_output("single_cnt", match_cnt, 1);
    check_output("single_cause", fail_cause, 0);
    check_output("single_busy_lo", busy, 0);

    // Three back-to-back writes
    cfg_write(0, 32'h10, 1);
    cfg_write(1, 32'h14, 2);
    cfg_write(2, 32'h18, 3);
    arm(3);
    apply_stimulus(32'h10, 1);
    apply_stimulus(32'h14, 2);
    check_output("seq_mid_busy", busy, 1);
    check_output("seq_mid_cnt", match_cnt, 2);
    apply_stimulus(32'h18, 3);
    check_output("seq_pass", pass, 1);
    check_output("seq_cnt", match_cnt, 3);

    // Data mismatch on the middle write
    arm(3);
    apply_stimulus(32'h10, 1);
    apply_stimulus(32'h14, 5);
    check_output("data_fail", fail, 1);
    check_output("data_cause", fail_cause, 2);
    check_output("data_idx", fail_idx, 1);
    check_output("data_fdata", fail_data, 5);
    check_output("data_faddr", fail_addr, 32'h14);
    check_output("data_cnt", match_cnt, 1);
    apply_stimulus(32'h18, 3);
    check_output("data_sticky", fail, 1);
    check_output("data_sticky_cnt", match_cnt, 1);

    // Address mismatch, with cfg write landing in the same cycle as start
    cfg_we = 1'b1; cfg_idx = 0; cfg_addr = 80; cfg_data = 32'hFFFF_FFFA;
    cfg_len = 1; start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    check_output("addr_busy", busy, 1);
    apply_stimulus(84, 7);
`ifdef MEMCHK_FILTER_EN
    check_output("filt_busy", busy, 1);
    check_output("filt_nofail", fail, 0);
    apply_stimulus(80, 32'hFFFF_FFFA);
    check_output("filt_pass", pass, 1);
    check_output("filt_cnt", match_cnt, 1);
`else
    check_output("addr_fail", fail, 1);
    check_output("addr_cause", fail_cause, 1);
    check_output("addr_faddr", fail_addr, 84);
    check_output("addr_fdata", fail_data, 7);
    check_output("addr_idx", fail_idx, 0);
`endif

    // Out-of-range cfg index must not alias onto entry 0
    cfg_write(8, 32'h99, 32'h99);
    arm(1);
    apply_stimulus(80, 32'hFFFF_FFFA);
    check_output("oob_pass", pass, 1);

    // Watchdog: fail exactly 20 cycles after busy rises; TIMEOUT=0 never fires
    reset = 1'b1; #1; reset = 1'b0;
    tick();
    arm(1);
    check_output("wd_busy", busy, 1);
    for (int i = 0; i < 19; i++) tick();
    check_output("wd_not_yet", fail, 0);
    tick();
    check_output("wd_fail", fail, 1);
    check_output("wd_cause", fail_cause, 3);
    check_output("wd_faddr", fail_addr, 0);
    for (int i = 0; i < 4980; i++) tick();
    check_output("nowd_busy", nw_busy, 1);
    check_output("nowd_nofail", nw_fail, 0);

    // Asynchronous reset mid-RUN, then replay retained table
    cfg_write(1, 32'h14, 2);
    cfg_write(2, 32'h18, 3);
    arm(3);
    apply_stimulus(80, 32'hFFFF_FFFA);
    check_output("rst_pre_cnt", match_cnt, 1);
    #2 reset = 1'b1;
    #1;
    check_output("rst_async_busy", busy, 0);
    check_output("rst_async_cnt", match_cnt, 0);
    check_output("rst_async_done", done, 0);
    reset = 1'b0;
    tick();
    arm(3);
    apply_stimulus(80, 32'hFFFF_FFFA);
    apply_stimulus(32'h14, 2);
    apply_stimulus(32'h18, 3);
    check_output("replay_pass", pass, 1);
    check_output("replay_cnt", match_cnt, 3);

    // Zero length passes immediately
    arm(0);
    check_output("len0_pass", pass, 1);
    check_output("len0_busy", busy, 0);
    check_output("len0_cnt", match_cnt, 0);

    // start and cfg_we during RUN are ignored
    arm(2);
    apply_stimulus(80, 32'hFFFF_FFFA);
    cfg_write(1, 32'h44, 9);
    cfg_len = 0; start = 1'b1;
    tick();
    start = 1'b0;
    check_output("ign_busy", busy, 1);
    check_output("ign_cnt", match_cnt, 1);
    for (int i = 0; i < 17; i++) tick();
    check_output("ign_wd_not_yet", fail, 0);
    tick();
    check_output("ign_wd_fail", fail, 1);
    check_output("ign_wd_cause", fail_cause, 3);
    check_output("ign_wd_idx", fail_idx, 1);
    arm(2);
    apply_stimulus(80, 32'hFFFF_FFFA);
    apply_stimulus(32'h14, 2);
    check_output("ign_cfg_pass", pass, 1);
    check_output("ign_cfg_cnt", match_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
